// File: rtl/ram_arbiter.sv
// ram_arbiter: two-master arbiter and access sequencer for the single-port data RAM.
// Define RAM_ARB_RR_EN for round-robin tie-breaking; left undefined, master 0 has fixed priority.
module ram_arbiter #(
    parameter int AW     = 10,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rstn,

    input  logic          m0_req,
    input  logic [3:0]    m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ack,

    input  logic          m1_req,
    input  logic [3:0]    m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ack,

    output logic [AW-1:0] ram_addr,
    output logic [3:0]    ram_wea,
    output logic [DW-1:0] ram_dina,
    input  logic [DW-1:0] ram_douta,

    output logic [1:0]    gnt,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE
    } state_t;

    localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

    state_t        state_q;
    logic [1:0]    cnt_q;
    logic          win_q;
    logic          rd_q;
`ifdef RAM_ARB_RR_EN
    logic          last_q;
`endif

    logic          pick1_d;
    logic [3:0]    sel_we_d;
    logic [AW-1:0] sel_addr_d;
    logic [DW-1:0] sel_wdata_d;

    always_comb begin
`ifdef RAM_ARB_RR_EN
        // On a tie master 1 wins only if master 0 was served last.
        pick1_d = m1_req & (~m0_req | ~last_q);
`else
        pick1_d = m1_req & ~m0_req;
`endif
        sel_we_d    = pick1_d ? m1_we    : m0_we;
        sel_addr_d  = pick1_d ? m1_addr  : m0_addr;
        sel_wdata_d = pick1_d ? m1_wdata : m0_wdata;
    end

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            win_q    <= 1'b0;
            rd_q     <= 1'b0;
`ifdef RAM_ARB_RR_EN
            last_q   <= 1'b1;
`endif
            gnt      <= '0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
            ram_addr <= '0;
            ram_wea  <= '0;
            ram_dina <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m0_req | m1_req) begin
                        win_q    <= pick1_d;
                        rd_q     <= (sel_we_d == 4'h0);
                        ram_addr <= sel_addr_d;
                        ram_dina <= sel_wdata_d;
                        ram_wea  <= sel_we_d;
                        gnt      <= pick1_d ? 2'b10 : 2'b01;
`ifdef RAM_ARB_RR_EN
                        last_q   <= pick1_d;
`endif
                        state_q  <= ACCESS;
                    end
                end
                ACCESS: begin
                    ram_wea <= '0;
                    cnt_q   <= LAT_M1;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // ram_douta is valid in the last WAIT cycle; capture it with the ack.
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                        if (win_q) begin
                            m1_ack <= 1'b1;
                            if (rd_q) m1_rdata <= ram_douta;
                        end else begin
                            m0_ack <= 1'b1;
                            if (rd_q) m0_rdata <= ram_douta;
                        end
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                DONE: begin
                    m0_ack  <= 1'b0;
                    m1_ack  <= 1'b0;
                    gnt     <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
